// File: rtl/fxp_pkg.sv
// -----------------------------------------------------------------------------
// fxp_pkg
// Shared Q8.7 fixed-point definitions for the ODE accelerator datapath.
// No ports; provides format constants and the signed 16-bit fixed-point type.
// -----------------------------------------------------------------------------
package fxp_pkg;

    localparam int          FXP_W       = 16;
    localparam int          FXP_FRAC    = 7;
    localparam logic [31:0] FXP_ROUND   = 32'h40;
    localparam int          FXP_OVF_MSB = 31;
    localparam int          FXP_OVF_LSB = 22;

    typedef logic signed [15:0] fxp_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// fp_mult_arbiter_if
// Request/response bundle between the ODE datapath requesters and the shared
// multiplier arbiter.
//   req_valid/req_a/req_b : per-requester request and packed Q8.7 operands
//   req_ready             : one-hot grant back to the requesters
//   resp_*                : tagged product, overflow flag, valid pulse
//   ovf_sticky/ovf_clr    : sticky overflow status and its clear strobe
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface fp_mult_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [15:0]           resp_result;
    logic                  resp_ovf;
    logic                  ovf_sticky;
    logic                  ovf_clr;

    modport master (
        output req_valid, req_a, req_b, ovf_clr,
        input  req_ready, resp_valid, resp_id, resp_result, resp_ovf, ovf_sticky
    );

    modport slave (
        input  req_valid, req_a, req_b, ovf_clr,
        output req_ready, resp_valid, resp_id, resp_result, resp_ovf, ovf_sticky
    );

endinterface

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
// Combinational Q8.7 x Q8.7 multiply with round-half-up and overflow detect.
//   a, b    : signed Q8.7 operands
//   result  : rounded Q8.7 product (wraps on overflow)
//   ovf     : product does not fit in Q8.7
// -----------------------------------------------------------------------------
module multiplier
    import fxp_pkg::*;
(
    input  fxp_t a,
    input  fxp_t b,
    output fxp_t result,
    output logic ovf
);
    logic signed [31:0]  p;
    logic [31:0]         q;
    logic [FXP_FRAC-1:0] unused_lsb;

    assign p = 32'(a) * 32'(b);
    assign q = p + FXP_ROUND;

    // Taking bits [22:7] is the arithmetic shift by FXP_FRAC truncated to 16 bits.
    assign result     = q[FXP_FRAC +: FXP_W];
    assign unused_lsb = q[FXP_FRAC-1:0];

    // Everything from bit 22 up must be pure sign extension of the result.
    assign ovf = !((&q[FXP_OVF_MSB:FXP_OVF_LSB]) || (~|q[FXP_OVF_MSB:FXP_OVF_LSB]));

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered last-grant pointer.
//   clk, rst   : clock, synchronous active-high reset
//   req        : request vector
//   advance    : a grant was taken this cycle; move the pointer to it
//   grant      : one-hot grant (combinational)
//   grant_idx  : encoded index of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IDW = $clog2(N);

    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] cand;

    // Walk last_grant+1 .. last_grant+N (mod N); the first requester hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDW'((int'(last_grant) + k) % N);
            if (grant == '0 && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Reset to N-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDW'(N - 1);
        end else if (advance) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// -----------------------------------------------------------------------------
// fp_mult_arbiter
// Shares one Q8.7 multiplier among NUM_REQ requesters. Round-robin grant,
// S1 registers the granted operands, S2 multiplies/rounds and registers the
// tagged result, so a grant in cycle t returns resp_valid in cycle t+2.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_mult_arbiter_if slave port (requests, grants, responses,
//              sticky overflow status and clear)
// -----------------------------------------------------------------------------
module fp_mult_arbiter
    import fxp_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    fp_mult_arbiter_if.slave    bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               transfer;
    fxp_t               sel_a;
    fxp_t               sel_b;

    logic               s1_valid;
    fxp_t               s1_a;
    fxp_t               s1_b;
    logic [ID_W-1:0]    s1_id;

    fxp_t               mult_result;
    logic               mult_ovf;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (bus.req_valid),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign bus.req_ready = rst ? '0 : grant;
    assign transfer      = |(bus.req_valid & bus.req_ready);

    always_comb begin
        sel_a = bus.req_a[FXP_W*grant_idx +: FXP_W];
        sel_b = bus.req_b[FXP_W*grant_idx +: FXP_W];
    end

    // S1: capture the granted operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else begin
            s1_valid <= transfer;
            if (transfer) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= grant_idx;
            end
        end
    end

    multiplier u_mult (
        .a      (s1_a),
        .b      (s1_b),
        .result (mult_result),
        .ovf    (mult_ovf)
    );

    // S2: register the product. Sticky set has priority over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.resp_valid  <= 1'b0;
            bus.resp_ovf    <= 1'b0;
            bus.resp_id     <= '0;
            bus.resp_result <= '0;
            bus.ovf_sticky  <= 1'b0;
        end else begin
            bus.resp_valid <= s1_valid;
            bus.resp_ovf   <= s1_valid & mult_ovf;
            if (s1_valid) begin
                bus.resp_id     <= s1_id;
                bus.resp_result <= mult_result;
            end
            if (bus.resp_valid && bus.resp_ovf) begin
                bus.ovf_sticky <= 1'b1;
            end else if (bus.ovf_clr) begin
                bus.ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fp_mult_arbiter
// Directed bench for fp_mult_arbiter (NUM_REQ = 4) with hand-computed results.
// -----------------------------------------------------------------------------
module tb_fp_mult_arbiter;

    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fp_mult_arbiter_if #(.NUM_REQ(NR)) bus ();

    fp_mult_arbiter #(.NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt = 0;
    int miscmp  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[16*i +: 16] = a;
        bus.req_b[16*i +: 16] = b;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.ovf_clr   = 1'b0;
        tick();
        tick();

        // Reset state; grants must stay low while rst is high.
        bus.req_valid = '1;
        #1;
        check("rst_ready",  32'(bus.req_ready),   32'h0);
        check("rst_rvalid", 32'(bus.resp_valid),  32'h0);
        check("rst_result", 32'(bus.resp_result), 32'h0);
        check("rst_id",     32'(bus.resp_id),     32'h0);
        check("rst_ovf",    32'(bus.resp_ovf),    32'h0);
        check("rst_sticky", 32'(bus.ovf_sticky),  32'h0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        // Basic product: 1.5 * 2.0 from requester 2.
        set_op(2, 16'h00C0, 16'h0100);
        bus.req_valid = 4'b0100;
        #1;
        check("basic_ready", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        check("basic_lat1", 32'(bus.resp_valid), 32'h0);
        tick();
        check("basic_rvalid", 32'(bus.resp_valid),  32'h1);
        check("basic_id",     32'(bus.resp_id),     32'h2);
        check("basic_result", 32'(bus.resp_result), 32'h0180);
        check("basic_ovf",    32'(bus.resp_ovf),    32'h0);
        tick();
        check("basic_pulse", 32'(bus.resp_valid), 32'h0);

        // Negative rounding: -1.0 * 3.0 from requester 0 (pointer at 2 wraps to 0).
        set_op(0, 16'hFF80, 16'h0180);
        bus.req_valid = 4'b0001;
        #1;
        check("neg_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        tick();
        check("neg_rvalid", 32'(bus.resp_valid),  32'h1);
        check("neg_id",     32'(bus.resp_id),     32'h0);
        check("neg_result", 32'(bus.resp_result), 32'hFE80);
        check("neg_ovf",    32'(bus.resp_ovf),    32'h0);

        // Overflow: 128.0 * 2.0 from requester 1.
        set_op(1, 16'h4000, 16'h0100);
        bus.req_valid = 4'b0010;
        #1;
        check("ovf_ready", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        tick();
        check("ovf_rvalid", 32'(bus.resp_valid),  32'h1);
        check("ovf_id",     32'(bus.resp_id),     32'h1);
        check("ovf_result", 32'(bus.resp_result), 32'h8000);
        check("ovf_flag",   32'(bus.resp_ovf),    32'h1);
        check("ovf_sticky_early", 32'(bus.ovf_sticky), 32'h0);
        tick();
        check("ovf_sticky_set", 32'(bus.ovf_sticky), 32'h1);
        check("ovf_flag_clear", 32'(bus.resp_ovf),   32'h0);

        // Second overflow from requester 3 with ovf_clr in the same cycle: set wins.
        set_op(3, 16'h4000, 16'h0100);
        bus.req_valid = 4'b1000;
        #1;
        check("ovf2_ready", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        tick();
        check("ovf2_flag", 32'(bus.resp_ovf), 32'h1);
        check("ovf2_id",   32'(bus.resp_id),  32'h3);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("sticky_set_wins", 32'(bus.ovf_sticky), 32'h1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("sticky_cleared", 32'(bus.ovf_sticky), 32'h0);

        // Round-robin from reset: all four held valid; requester i computes 1.0*(i+1).
        for (int i = 0; i < NR; i++) set_op(i, 16'h0080, 16'((i + 1) * 128));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) check($sformatf("rr_ready%0d", k), 32'(bus.req_ready), 32'(1 << (k % 4)));
            tick();
            if (k >= 1 && k <= 8) begin
                check($sformatf("rr_rvalid%0d", k - 1), 32'(bus.resp_valid),  32'h1);
                check($sformatf("rr_id%0d", k - 1),     32'(bus.resp_id),     32'((k - 1) % 4));
                check($sformatf("rr_result%0d", k - 1), 32'(bus.resp_result), 32'(128 * ((k - 1) % 4 + 1)));
            end
        end
        check("rr_drained", 32'(bus.resp_valid), 32'h0);

        // Skip idle requesters: only 1 and 3 valid, pointer at 3 -> 1,3,1,3.
        for (int k = 0; k < 6; k++) begin
            bus.req_valid = (k < 4) ? 4'b1010 : 4'b0000;
            #1;
            if (k < 4) check($sformatf("skip_ready%0d", k), 32'(bus.req_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
            tick();
            if (k >= 1 && k <= 4) begin
                check($sformatf("skip_rvalid%0d", k - 1), 32'(bus.resp_valid), 32'h1);
                check($sformatf("skip_id%0d", k - 1), 32'(bus.resp_id), ((k - 1) % 2 == 0) ? 32'h1 : 32'h3);
            end
        end

        // Reset one cycle after an accept: the in-flight request is dropped.
        bus.req_valid = 4'b0100;
        #1;
        check("mid_ready", 32'(bus.req_ready), 32'h4);
        tick();
        rst = 1'b1;
        #1;
        check("mid_ready_in_rst", 32'(bus.req_ready), 32'h0);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        check("mid_no_resp1", 32'(bus.resp_valid), 32'h0);
        tick();
        check("mid_no_resp2", 32'(bus.resp_valid), 32'h0);
        bus.req_valid = 4'b1111;
        #1;
        check("mid_first_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        tick();
        check("mid_rvalid", 32'(bus.resp_valid),  32'h1);
        check("mid_id",     32'(bus.resp_id),     32'h0);
        check("mid_result", 32'(bus.resp_result), 32'h0080);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Pipelined round-robin arbiter that shares one Q8.7 fixed-point multiplier core among `NUM_REQ` requesters (ODE stage evaluators, step-size update logic). Each cycle it grants at most one requester, registers that requester's operands, multiplies them with rounding, and returns the tagged result and overflow flag two cycles later. It also keeps a sticky overflow status for the accelerator control unit. It sits between the ODE datapath units and the single multiplier instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag (derived).

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request; held with operands until accepted.
- `req_a`  in  16*NUM_REQ  Q8.7 signed multiplicands; requester i occupies bits [16i+15:16i].
- `req_b`  in  16*NUM_REQ  Q8.7 signed multipliers, same packing.
- `req_ready`  out  NUM_REQ  one-hot grant, combinational from `req_valid` and the RR pointer; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  1  result valid, one cycle pulse per accepted request.
- `resp_id`  out  ID_W  index of the requester that owns the result.
- `resp_result`  out  16  Q8.7 product.
- `resp_ovf`  out  1  overflow flag for this result.
- `ovf_sticky`  out  1  set by any `resp_ovf`, held until cleared.
- `ovf_clr`  in  1  clears `ovf_sticky`.

## Operation
- **Arbitration:**
  - Round-robin. The search starts at `last_grant+1` modulo NUM_REQ.
  - At most one `req_ready` bit is high, and only for a valid requester.
  - `last_grant` updates only on a transfer.
  - Non-requesting slots are skipped with no idle cycle.
- **Stage S1 (accept):** on a transfer, register `a`, `b`, the id and `s1_valid=1`. With no transfer, `s1_valid=0`.
- **Stage S2 (compute):**
  - `p = s1_a * s1_b` (32-bit signed), then `q = p + 64`, a rounding constant of 0x00000040.
  - `resp_result = (q >>> 7)[15:0]`.
  - `resp_ovf = !(q[31:22] all 0 or all 1)`.
  - Register the result, flag, id and valid.
- **No back-pressure on responses:** requesters must sink `resp_valid` whenever it is asserted.
- **Sticky overflow:**
  - Set when `resp_valid & resp_ovf`.
  - Cleared by `ovf_clr`.
  - Set wins when both occur in the same cycle.
- **Reset:**
  - `last_grant` = NUM_REQ-1, so requester 0 has priority first.
  - `s1_valid`, `resp_valid`, `resp_ovf`, `ovf_sticky` = 0.
  - `resp_id`, `resp_result` = 0.
  - `req_ready` stays 0 while `rst` is high.
- **Reset mid-operation:** in-flight S1/S2 entries are discarded and no `resp_valid` is emitted for them. Requesters must re-issue.

## Timing
- Accept in cycle t gives `resp_valid` in cycle t+2. Latency is fixed at 2, with no variation.
- Throughput is one multiply per cycle. Results return in acceptance order.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- A requester may keep `req_valid` high back-to-back. Under contention it is re-granted no sooner than after every other active requester has had one grant (fairness bound: one wait of NUM_REQ-1 cycles).
- Simultaneous arrival of all requests in the same cycle resolves strictly in RR order from the pointer.

## Structure
- Shared package `fxp_pkg`:
  - Q-format constants: `FXP_W=16`, `FXP_FRAC=7`, `FXP_ROUND=32'h40`, `FXP_OVF_MSB=31`, `FXP_OVF_LSB=22`.
  - `typedef logic signed [15:0] fxp_t`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: request vector and advance strobe.
  - Outputs: one-hot grant and encoded index.
  - Holds the pointer.
- The Q8.7 multiply/round/overflow logic is instantiated as the team's existing combinational `multiplier` core inside S2, with its output registered.

## Test plan
- **Basic product:** single request from req 2 with a=0x00C0 (1.5), b=0x0100 (2.0) → two cycles later `resp_valid=1`, `resp_id=2`, `resp_result=0x0180`, `resp_ovf=0`.
- **Negative rounding:** a=0xFF80 (-1.0), b=0x0180 (3.0) → `resp_result=0xFE80`, `resp_ovf=0`.
- **Overflow and sticky status:** a=0x4000 (128.0), b=0x0100 → `resp_result=0x8000`, `resp_ovf=1`, `ovf_sticky=1` from the next cycle.
  - Pulse `ovf_clr` in the same cycle as a second overflow → sticky stays 1.
  - Pulse `ovf_clr` alone → sticky goes to 0.
- **Round-robin fairness:** all 4 requesters held valid from reset for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 responses with matching ids, each 2 cycles after its grant.
- **Skipping idle requesters:** only requesters 1 and 3 valid → grants alternate 1,3,1,3 with no idle cycle; `req_ready[0]` and `req_ready[2]` stay 0.
- **Reset mid-operation:** assert `rst` one cycle after an accept → no `resp_valid` for that request; after reset, the first grant goes to requester 0 when all are valid.
